// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: FSM state encoding and default widths.
package stack_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_WAIT = 3'd3,
    S_ACK     = 3'd4
  } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Handshake and stack-memory bus between the control unit / memory (master) and stack_ctrl (slave).
interface stack_ctrl_if
  import stack_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              req_push;
  logic              req_pop;
  logic [DATA_W-1:0] push_data;
  logic              ack;
  logic [DATA_W-1:0] pop_data;
  logic [ADDR_W-1:0] stk_addr;
  logic              stk_wren;
  logic [DATA_W-1:0] stk_wdata;
  logic [DATA_W-1:0] stk_rdata;

  modport master (
    output req_push, req_pop, push_data, stk_rdata,
    input  ack, pop_data, stk_addr, stk_wren, stk_wdata
  );

  modport slave (
    input  req_push, req_pop, push_data, stk_rdata,
    output ack, pop_data, stk_addr, stk_wren, stk_wdata
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller driving an external synchronous-read stack memory over a four-phase handshake.
// Optional macro STACK_CTRL_STICKY_ERR_EN: error flags stay set until reset instead of only during ACK.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  stack_ctrl_if.slave   bus,
  output logic [ADDR_W:0] count,
  output logic          full,
  output logic          empty,
  output logic          err_ovf,
  output logic          err_udf
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [ADDR_W:0]   count_m1;

  logic              ack_o;
  logic              wren_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] wdata_o;

  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == '0);
  assign count_m1 = count_q - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      pop_data_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pop_data_q <= pop_data_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Push has priority over pop; errors go straight to ACK without touching count or memory.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pop_data_d = pop_data_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_push) begin
          if (!full) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_ACK;
            ovf_d   = 1'b1;
          end
        end else if (bus.req_pop) begin
          if (!empty) begin
            state_d = S_RD_ADDR;
          end else begin
            state_d = S_ACK;
            udf_d   = 1'b1;
          end
        end
      end
      S_WRITE: begin
        state_d = S_ACK;
        count_d = count_q + ONE;
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        state_d    = S_ACK;
        pop_data_d = bus.stk_rdata;
        count_d    = count_m1;
      end
      S_ACK: begin
        if (!(bus.req_push || bus.req_pop)) begin
          state_d = S_IDLE;
`ifndef STACK_CTRL_STICKY_ERR_EN
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs are decoded from state so reset clears them without waiting for a clock.
  always_comb begin
    ack_o   = 1'b0;
    wren_o  = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    unique case (state_q)
      S_WRITE: begin
        wren_o  = 1'b1;
        addr_o  = count_q[ADDR_W-1:0];
        wdata_o = bus.push_data;
      end
      S_RD_ADDR, S_RD_WAIT: addr_o = count_m1[ADDR_W-1:0];
      S_ACK:                ack_o  = 1'b1;
      default: ;
    endcase
  end

  assign bus.ack       = ack_o;
  assign bus.stk_wren  = wren_o;
  assign bus.stk_addr  = addr_o;
  assign bus.stk_wdata = wdata_o;
  assign bus.pop_data  = pop_data_q;
  assign count         = count_q;
  assign err_ovf       = ovf_q;
  assign err_udf       = udf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: a queue-based stack model and timeline checked every cycle, plus literal spot checks.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] count;
  logic       full, empty, err_ovf, err_udf;

  stack_ctrl_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  stack_ctrl #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .err_ovf (err_ovf),
    .err_udf (err_udf)
  );

  always #5 clk = ~clk;

  // External stack memory with one-cycle registered read.
  logic [15:0] mem [32];
  always @(posedge clk) begin
    if (bus.stk_wren) mem[bus.stk_addr] <= bus.stk_wdata;
    bus.stk_rdata <= mem[bus.stk_addr];
  end

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0] q[$];
  int          m_count = 0;
  logic        m_ack = 0, m_wren = 0, m_ovf = 0, m_udf = 0;
  logic [4:0]  m_addr = 0;
  logic [15:0] m_wdata = 0, m_pop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack",      32'(bus.ack),       32'(m_ack));
      chk("count",    32'(count),         32'(m_count));
      chk("full",     32'(full),          32'(m_count == 32));
      chk("empty",    32'(empty),         32'(m_count == 0));
      chk("wren",     32'(bus.stk_wren),  32'(m_wren));
      chk("addr",     32'(bus.stk_addr),  32'(m_addr));
      chk("wdata",    32'(bus.stk_wdata), 32'(m_wdata));
      chk("pop_data", 32'(bus.pop_data),  32'(m_pop));
      chk("err_ovf",  32'(err_ovf),       32'(m_ovf));
      chk("err_udf",  32'(err_udf),       32'(m_udf));
    end
  end

  task automatic model_reset();
    q.delete();
    m_count = 0; m_ack = 0; m_wren = 0; m_addr = 0;
    m_wdata = 0; m_pop = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_push = 1'b0; bus.req_pop = 1'b0; bus.push_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One full handshake; the model timeline follows the latencies push=2, pop=3, error=1.
  task automatic op(input bit push, input bit pop, input logic [15:0] data, input int hold);
    bit is_push, is_ovf, is_pop;
    int lat;
    is_push = push && (m_count < 32);
    is_ovf  = push && (m_count == 32);
    is_pop  = !push && pop && (m_count > 0);
    lat = is_push ? 2 : (is_pop ? 3 : 1);
    @(negedge clk);
    bus.req_push = push; bus.req_pop = pop; bus.push_data = data;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (is_push && c == 1) begin
        m_wren = 1; m_addr = 5'(m_count); m_wdata = data;
      end else if (is_push) begin
        m_wren = 0; m_addr = 0; m_wdata = 0;
        q.push_back(data); m_count++; m_ack = 1;
      end else if (is_pop && c < 3) begin
        m_addr = 5'(m_count - 1);
      end else if (is_pop) begin
        m_addr = 0; m_pop = q.pop_back(); m_count--; m_ack = 1;
      end else begin
        m_ack = 1;
        if (is_ovf) m_ovf = 1; else m_udf = 1;
      end
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus.req_push = 1'b0; bus.req_pop = 1'b0;
    @(posedge clk); #1;
    m_ack = 0;
`ifndef STACK_CTRL_STICKY_ERR_EN
    m_ovf = 0; m_udf = 0;
`endif
  endtask

  initial begin
    bus.req_push = 1'b0; bus.req_pop = 1'b0; bus.push_data = '0;
    #1;
    chk("rst_ack",   32'(bus.ack), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_wren",  32'(bus.stk_wren), 0);
    do_reset();

    // Single push
    op(1, 0, 16'h00A5, 0);
    chk("t1_count", 32'(count), 1);
    chk("t1_empty", 32'(empty), 0);
    chk("t1_mem0",  32'(mem[0]), 32'h00A5);

    // LIFO order
    do_reset();
    op(1, 0, 16'h1111, 0);
    op(1, 0, 16'h2222, 1);
    op(0, 1, 16'h0000, 0);
    chk("t2_pop",   32'(bus.pop_data), 32'h2222);
    chk("t2_count", 32'(count), 1);
    op(0, 1, 16'h0000, 0);
    chk("t2_pop2",  32'(bus.pop_data), 32'h1111);

    // Underflow
    do_reset();
    op(0, 1, 16'h0000, 2);
    chk("t3_count", 32'(count), 0);

    // Fill, then overflow
    do_reset();
    for (int i = 0; i < 32; i++) op(1, 0, 16'(16'h0100 + i), 0);
    chk("t4_full", 32'(full), 1);
    op(1, 0, 16'hFFFF, 1);
    chk("t4_count", 32'(count), 32);
    op(0, 1, 16'h0000, 0);
    chk("t4_top", 32'(bus.pop_data), 32'h011F);
    op(0, 1, 16'h0000, 0);
    chk("t4_next", 32'(bus.pop_data), 32'h011E);

    // Simultaneous push and pop: push wins, ack held while requests stay high
    do_reset();
    for (int i = 0; i < 3; i++) op(1, 0, 16'(16'h0010 + i), 0);
    op(1, 1, 16'h0042, 3);
    chk("t5_count", 32'(count), 4);
    op(0, 1, 16'h0000, 0);
    chk("t5_pop", 32'(bus.pop_data), 32'h0042);

    // Reset asserted in the middle of a WRITE
    do_reset();
    op(1, 0, 16'h0007, 0);
    @(negedge clk);
    bus.req_push = 1'b1; bus.push_data = 16'h0BAD;
    @(posedge clk); #2;
    chk("t6_in_write", 32'(bus.stk_wren), 1);
    rst_n = 1'b0;
    bus.req_push = 1'b0;
    #1;
    chk("t6_wren",  32'(bus.stk_wren), 0);
    chk("t6_addr",  32'(bus.stk_addr), 0);
    chk("t6_wdata", 32'(bus.stk_wdata), 0);
    chk("t6_ack",   32'(bus.ack), 0);
    chk("t6_count", 32'(count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_idle_count", 32'(count), 0);
    op(1, 0, 16'h0C0C, 0);
    chk("t6_after", 32'(count), 1);
    chk("t6_mem0", 32'(mem[0]), 32'h0C0C);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
